// File: rtl/alu_negative.sv
// alu_negative: registered two's-complement negation with zero/sign/overflow flags; NEG_SATURATE_EN clamps -MIN to MAX
module alu_negative #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             neg_en,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] x,
    output logic             out_valid,
    output logic             zero,
    output logic             neg,
    output logic             ovf
);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
    logic [WIDTH-1:0] x_q, x_d;
    logic             valid_q, zero_q, neg_q, ovf_q, ovf_d;
    // next result: negate or pass, with the most-negative operand flagged as overflow
    always_comb begin
        ovf_d = neg_en && (in == MIN_VAL);
`ifdef NEG_SATURATE_EN
        x_d = ovf_d ? ~MIN_VAL : neg_en ? ~in + ONE : in;
`else
        x_d = neg_en ? ~in + ONE : in;
`endif
    end
    // capture on in_valid, hold result and flags otherwise; reset wins
    always_ff @(posedge clk) begin
        if (reset) begin
            x_q     <= '0;
            valid_q <= 1'b0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                x_q    <= x_d;
                zero_q <= x_d == '0;
                neg_q  <= x_d[WIDTH-1];
                ovf_q  <= ovf_d;
            end
        end
    end
    assign x         = x_q;
    assign out_valid = valid_q;
    assign zero      = zero_q;
    assign neg       = neg_q;
    assign ovf       = ovf_q;
endmodule

// File: tb/tb_alu_negative.sv
// tb_alu_negative: directed and randomized checks of alu_negative against an integer-arithmetic model
module tb_alu_negative;
    logic       clk = 1'b0;
    logic       reset, in_valid, neg_en;
    logic [7:0] in;
    logic [7:0] x;
    logic       out_valid, zero, neg, ovf;
    int         n_vec = 0;
    int         n_err = 0;
    logic [10:0] held;

    alu_negative #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .neg_en(neg_en), .in(in),
        .x(x), .out_valid(out_valid), .zero(zero), .neg(neg), .ovf(ovf)
    );

    always #5 clk = ~clk;

    // returns {x, zero, neg, ovf} from signed integer arithmetic
    function automatic logic [10:0] model(input logic ne, input logic [7:0] a);
        int s, r;
        logic o;
        logic [7:0] y;
        s = (a >= 8'd128) ? int'(a) - 256 : int'(a);
        r = ne ? -s : s;
        o = r > 127;
`ifdef NEG_SATURATE_EN
        if (o) r = 127;
`endif
        y = 8'(r);
        return {y, y == 8'd0, y[7], o};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; neg_en = 1'b0; in = 8'h5A;
        tick(); tick();
        reset = 1'b0;
        tick();
        n_vec++;
        if ({x, out_valid, zero, neg, ovf} !== 12'h000) begin
            n_err++;
            $display("FAIL reset: got x=%h v=%b z=%b n=%b o=%b want all zero", x, out_valid, zero, neg, ovf);
        end
        held = 11'h0;
    endtask

    task automatic apply(input string name, input logic v, input logic ne, input logic [7:0] a);
        logic [11:0] exp;
        in_valid = v; neg_en = ne; in = a;
        tick();
        if (v) held = model(ne, a);
        exp = {held[10:3], v, held[2:0]};
        n_vec++;
        if ({x, out_valid, zero, neg, ovf} !== exp) begin
            n_err++;
            $display("FAIL %s: in=%h ne=%b got x=%h v=%b z=%b n=%b o=%b want x=%h v=%b z=%b n=%b o=%b",
                     name, a, ne, x, out_valid, zero, neg, ovf, exp[11:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic test_zero();
        apply("neg_zero", 1'b1, 1'b1, 8'h00);
        n_vec++;
        if ({x, zero, ovf} !== {8'h00, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL neg_zero_const: got x=%h z=%b o=%b want x=00 z=1 o=0", x, zero, ovf);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] ops [5] = '{8'h01, 8'h81, 8'hFF, 8'hFE, 8'h05};
        logic [7:0] res [5] = '{8'hFF, 8'h7F, 8'h01, 8'h02, 8'hFB};
        for (int i = 0; i < 5; i++) begin
            apply("b2b", 1'b1, 1'b1, ops[i]);
            n_vec++;
            if (x !== res[i] || out_valid !== 1'b1) begin
                n_err++;
                $display("FAIL b2b_const[%0d]: got x=%h v=%b want x=%h v=1", i, x, out_valid, res[i]);
            end
        end
    endtask

    task automatic test_min();
        apply("neg_min", 1'b1, 1'b1, 8'h80);
`ifdef NEG_SATURATE_EN
        n_vec++;
        if ({x, neg, ovf} !== {8'h7F, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL neg_min_const: got x=%h n=%b o=%b want x=7f n=0 o=1", x, neg, ovf);
        end
`else
        n_vec++;
        if ({x, neg, ovf} !== {8'h80, 1'b1, 1'b1}) begin
            n_err++;
            $display("FAIL neg_min_const: got x=%h n=%b o=%b want x=80 n=1 o=1", x, neg, ovf);
        end
`endif
        apply("pass_min", 1'b1, 1'b0, 8'h80);
    endtask

    task automatic test_pass_hold();
        apply("pass", 1'b1, 1'b0, 8'hC1);
        for (int i = 0; i < 3; i++) begin
            apply("hold", 1'b0, 1'($urandom), 8'($urandom));
            n_vec++;
            if (x !== 8'hC1 || out_valid !== 1'b0 || neg !== 1'b1 || ovf !== 1'b0) begin
                n_err++;
                $display("FAIL hold_const[%0d]: got x=%h v=%b n=%b o=%b want x=c1 v=0 n=1 o=0", i, x, out_valid, neg, ovf);
            end
        end
    endtask

    task automatic test_reset_mid();
        apply("pre_rst", 1'b1, 1'b1, 8'h33);
        reset = 1'b1; in_valid = 1'b1; neg_en = 1'b1; in = 8'h87;
        tick();
        held = 11'h0;
        n_vec++;
        if ({x, out_valid, zero, neg, ovf} !== 12'h000) begin
            n_err++;
            $display("FAIL reset_mid: got x=%h v=%b z=%b n=%b o=%b want all zero", x, out_valid, zero, neg, ovf);
        end
        reset = 1'b0;
        apply("post_rst", 1'b1, 1'b1, 8'h87);
        n_vec++;
        if (x !== 8'h79 || out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL post_rst_const: got x=%h v=%b want x=79 v=1", x, out_valid);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                reset = 1'b1; in_valid = 1'($urandom); neg_en = 1'($urandom); in = 8'($urandom);
                tick();
                held = 11'h0;
                n_vec++;
                if ({x, out_valid, zero, neg, ovf} !== 12'h000) begin
                    n_err++;
                    $display("FAIL rand_reset: got x=%h v=%b z=%b n=%b o=%b want all zero", x, out_valid, zero, neg, ovf);
                end
                reset = 1'b0;
            end else begin
                apply("random", $urandom_range(0, 3) != 0, 1'($urandom),
                      ($urandom_range(0, 7) == 0) ? 8'h80 : 8'($urandom));
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_back_to_back();
        test_min();
        test_pass_hold();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
